// File: rtl/nw_score_writer_if.sv
// Handshake and RAM-write bundle for nw_score_writer.
// master drives fill cells and start; slave is the writer itself.
interface nw_score_writer_if #(
  parameter int IW      = 8,
  parameter int JW      = 8,
  parameter int ADDR_W  = 15,
  parameter int SCORE_W = 9
);
  logic               start;
  logic               ins_valid;
  logic               ins_ready;
  logic [IW-1:0]      i;
  logic [JW-1:0]      j;
  logic [SCORE_W-1:0] max;
  logic               we;
  logic [ADDR_W-1:0]  addr_out;
  logic [SCORE_W-1:0] data_out;
  logic               init_done;
  logic               done;
  logic               err;

  modport master (
    output start, ins_valid, i, j, max,
    input  ins_ready, we, addr_out, data_out, init_done, done, err
  );

  modport slave (
    input  start, ins_valid, i, j, max,
    output ins_ready, we, addr_out, data_out, init_done, done, err
  );
endinterface

// File: rtl/nw_score_writer.sv
// Needleman-Wunsch score-matrix writer: gap boundary init, then fill-cell writes.
// Optional BOUNDS_CHECK_EN drops out-of-range fill cells and raises a sticky err.
module nw_score_writer #(
  parameter int N       = 128,
  parameter int M       = 128,
  parameter int SCORE_W = 9,
  parameter int GAP     = 1,
  parameter int IW      = $clog2(N+1),
  parameter int JW      = $clog2(M+1),
  parameter int ADDR_W  = $clog2((N+1)*(M+1))
) (
  input  logic             clk,
  input  logic             rst,
  nw_score_writer_if.slave bus
);
  localparam int KW  = (IW > JW) ? IW : JW;
  localparam int AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, INIT_ROW, INIT_COL, FILL, DONE} state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SCORE_W-1:0] data_q, data_d;
  logic               init_done_q, init_done_d;
  logic               done_q, done_d;
`ifdef BOUNDS_CHECK_EN
  logic               err_q, err_d;
  logic               oob;
`endif

  logic [AW1-1:0]     fill_addr, col_addr;
  logic [SCORE_W-1:0] init_data;
  logic               last_cell;

  // Full-width products, truncated afterwards so oversized values wrap
  assign fill_addr = (AW1'(bus.i) + AW1'(1)) * AW1'(M+1) + AW1'(bus.j) + AW1'(1);
  assign col_addr  = AW1'(k_q) * AW1'(M+1);
  assign init_data = SCORE_W'(32'd0 - 32'(k_q) * 32'(GAP));
  assign last_cell = (bus.i == IW'(N-1)) && (bus.j == JW'(M-1));
`ifdef BOUNDS_CHECK_EN
  assign oob       = (bus.i >= IW'(N)) || (bus.j >= JW'(M));
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    we_d        = 1'b0;
    addr_d      = '0;
    data_d      = '0;
    init_done_d = init_done_q;
    done_d      = done_q;
`ifdef BOUNDS_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // Cell (0,0) goes out straight off the start edge
        if (bus.start) begin
          state_d     = INIT_ROW;
          k_d         = KW'(1);
          we_d        = 1'b1;
          init_done_d = 1'b0;
          done_d      = 1'b0;
`ifdef BOUNDS_CHECK_EN
          err_d       = 1'b0;
`endif
        end
      end
      INIT_ROW: begin
        we_d   = 1'b1;
        addr_d = ADDR_W'(k_q);
        data_d = init_data;
        if (k_q == KW'(M)) begin
          state_d = INIT_COL;
          k_d     = KW'(1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      INIT_COL: begin
        we_d   = 1'b1;
        addr_d = col_addr[ADDR_W-1:0];
        data_d = init_data;
        if (k_q == KW'(N)) begin
          state_d     = FILL;
          init_done_d = 1'b1;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      FILL: begin
        if (bus.ins_valid) begin
`ifdef BOUNDS_CHECK_EN
          if (oob) begin
            err_d = 1'b1;
          end else begin
            we_d   = 1'b1;
            addr_d = fill_addr[ADDR_W-1:0];
            data_d = bus.max;
            if (last_cell) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
`else
          we_d   = 1'b1;
          addr_d = fill_addr[ADDR_W-1:0];
          data_d = bus.max;
          if (last_cell) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef BOUNDS_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      done_q      <= done_d;
`ifdef BOUNDS_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.ins_ready = (state_q == FILL);
  assign bus.we        = we_q;
  assign bus.addr_out  = addr_q;
  assign bus.data_out  = data_q;
  assign bus.init_done = init_done_q;
  assign bus.done      = done_q;
`ifdef BOUNDS_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: doc/nw_score_writer.md
# nw_score_writer

Score-matrix write port for the Needleman-Wunsch datapath, generalised to rectangular N×M alignments with configurable score width and gap penalty. An internal sequencer writes the first row and first column with the linear gap boundary, then accepts fill-cell results from the scoring engine through a valid/ready handshake. It produces registered write-enable, address and data for the score RAM, and flags completion when the last matrix cell is written.

## Interface

- N, 128, length of sequence A (matrix rows 1..N)
- M, 128, length of sequence B (matrix cols 1..M)
- SCORE_W, 9, two's-complement score width
- GAP, 1, gap penalty magnitude (positive integer)
- IW, $clog2(N+1), width of i
- JW, $clog2(M+1), width of j
- ADDR_W, $clog2((N+1)*(M+1)), RAM address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new matrix (sampled in IDLE or DONE)
- ins_valid  in  1  fill cell offered
- ins_ready  out  1  fill cell accepted this cycle when valid; combinational, equals (state==FILL)
- i  in  IW  fill row index, 0-based (cell row i+1)
- j  in  JW  fill column index, 0-based (cell col j+1)
- max  in  SCORE_W  cell score to store
- we  out  1  RAM write enable (registered)
- addr_out  out  ADDR_W  RAM address, row*(M+1)+col (registered)
- data_out  out  SCORE_W  RAM write data (registered)
- init_done  out  1  boundary initialisation complete
- done  out  1  last cell (N,M) written
- err  out  1  sticky out-of-range flag (see Configuration)

## Operation

- States: IDLE, INIT_ROW, INIT_COL, FILL, DONE.
- IDLE: outputs idle; start → INIT_ROW, counter k=0.
- INIT_ROW: each cycle write cell (0,k): addr=k, data=−k·GAP; k=0..M; after k=M → INIT_COL, k=1.
- INIT_COL: each cycle write cell (k,0): addr=k·(M+1), data=−k·GAP; k=1..N; after k=N → FILL.
- FILL: on ins_valid&&ins_ready, write addr=(i+1)·(M+1)+(j+1), data=max. Accepting i==N−1 && j==M−1 → DONE. Fill order is the engine's responsibility; no ordering check.
- DONE: done=1, init_done=1 held; start → INIT_ROW (new matrix, err cleared); otherwise stay.
- start in INIT_ROW/INIT_COL/FILL ignored. ins_valid outside FILL ignored (ins_ready=0).
- Arithmetic: init data is −k·GAP computed at full width then truncated to SCORE_W (wraps silently if N·GAP or M·GAP exceeds range). Address computed at ADDR_W+1 bits, truncated to ADDR_W.
- When we=0, addr_out and data_out are 0.

## Timing

- Reset values: we=0, addr_out=0, data_out=0, init_done=0, done=0, err=0, state IDLE.
- rst wins over all inputs; mid-operation reset aborts the matrix, no further writes.
- Latency: the write for a given cell appears on we/addr_out/data_out one cycle after the edge that sampled it (start edge → cell (0,0) on outputs next cycle).
- Init occupies exactly N+M+1 consecutive we cycles, no gaps.
- init_done rises the cycle state becomes FILL (together with the output of last column write); held through DONE; cleared on start or rst.
- done rises with the output of cell (N,M); held until start or rst.
- Back-to-back fill accepts supported: one write per cycle, no bubbles.

## Configuration

- BOUNDS_CHECK_EN defined: in FILL, an accepted cell with i≥N or j≥M produces no write (we=0), sets err (sticky until start/rst), and never triggers DONE.
- Not defined: no check; address computed and written as-is (wrap per width rules); err tied 0.

## Test plan

- N=4, M=3, GAP=2, SCORE_W=9: start → 4 writes addr 0,1,2,3 data 0x000,0x1FE,0x1FC,0x1FA, then addr 4,8,12,16 data 0x1FE,0x1FC,0x1FA,0x1F8; init_done high after 8th write.
- Fill i=1, j=2, max=5 → next cycle we=1, addr_out=11, data_out=5; ins_ready=0 during init confirmed.
- 12 back-to-back fill cells row-major ending i=3, j=2 → 12 consecutive writes, final addr 19, done=1 with it, ins_ready drops.
- rst asserted mid-INIT_COL → next cycle all outputs 0, IDLE; fresh start reproduces full init sequence.
- With BOUNDS_CHECK_EN: fill i=4, j=0 → no write, err=1 held; then i=3, j=2 → addr 19 written, done=1, err stays 1 until start.
- In DONE, start → err cleared, done/init_done cleared, init sequence restarts at addr 0.
